// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
// Posted-write buffer between the CPU data-memory port and the backing data RAM.
// CPU stores are queued in a circular FIFO and drained to the RAM over a
// valid/ready handshake. Loads are answered combinationally from the RAM's
// asynchronous read port, overridden by the youngest matching buffered store.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   MemWrite              CPU store request this cycle
//   Mem_WrAddr            CPU byte address (loads and stores), word granularity
//   Mem_WrData            CPU store data
//   ReadData              load data to CPU (combinational)
//   WrStall               buffer full; CPU must hold the store
//   bk_rd_addr/bk_rd_data backing RAM asynchronous read port
//   bk_wr_valid/ready     head-entry write handshake to the RAM
//   bk_wr_addr/bk_wr_data head entry, word aligned
//   buf_count             number of occupied entries
module dmem_store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [31:0]                Mem_WrAddr,
  input  logic [31:0]                Mem_WrData,
  output logic [31:0]                ReadData,
  output logic                       WrStall,
  output logic [31:0]                bk_rd_addr,
  input  logic [31:0]                bk_rd_data,
  output logic                       bk_wr_valid,
  input  logic                       bk_wr_ready,
  output logic [31:0]                bk_wr_addr,
  output logic [31:0]                bk_wr_data,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [29:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [PtrW-1:0] wp_q;
  logic [PtrW-1:0] rp_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            push;
  logic            pop;
  logic [PtrW-1:0] fwd_idx;

  // Stall and valid decode from registered occupancy only, so there is no
  // combinational path from bk_wr_ready back to the CPU.
  assign WrStall     = (cnt_q == CntW'(DEPTH));
  assign bk_wr_valid = (cnt_q != '0);
  assign push        = MemWrite && !WrStall;
  assign pop         = bk_wr_valid && bk_wr_ready;

  assign bk_rd_addr  = Mem_WrAddr;
  assign bk_wr_addr  = {addr_q[rp_q], 2'b00};
  assign bk_wr_data  = data_q[rp_q];
  assign buf_count   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        wp_q <= wp_q + PtrW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + PtrW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  // Entry contents are intentionally not reset; cnt_q == 0 hides them.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wp_q] <= Mem_WrAddr[31:2];
      data_q[wp_q] <= Mem_WrData;
    end
  end

  // Walk valid entries from oldest (rp) to youngest; the last match wins,
  // which selects the store closest to wp.
  always_comb begin
    ReadData = bk_rd_data;
    fwd_idx  = rp_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = rp_q + PtrW'(k);
      if ((CntW'(k) < cnt_q) && (addr_q[fwd_idx] == Mem_WrAddr[31:2])) begin
        ReadData = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Testbench for dmem_store_buffer: directed stimulus, a queue-based model of
// the buffer checked every cycle, and literal expectations for key scenarios.
module tb_dmem_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic                       clk;
  logic                       reset;
  logic                       MemWrite;
  logic [31:0]                Mem_WrAddr;
  logic [31:0]                Mem_WrData;
  logic [31:0]                ReadData;
  logic                       WrStall;
  logic [31:0]                bk_rd_addr;
  logic [31:0]                bk_rd_data;
  logic                       bk_wr_valid;
  logic                       bk_wr_ready;
  logic [31:0]                bk_wr_addr;
  logic [31:0]                bk_wr_data;
  logic [$clog2(DEPTH+1)-1:0] buf_count;

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .ReadData   (ReadData),
    .WrStall    (WrStall),
    .bk_rd_addr (bk_rd_addr),
    .bk_rd_data (bk_rd_data),
    .bk_wr_valid(bk_wr_valid),
    .bk_wr_ready(bk_wr_ready),
    .bk_wr_addr (bk_wr_addr),
    .bk_wr_data (bk_wr_data),
    .buf_count  (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];        // model of buffered stores, oldest first
  ent_t commits[$];  // writes the RAM has accepted, in order
  int   n_total;
  int   n_pass;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [31:0] bk);
    logic [31:0] r;
    r = bk;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].a[31:2] == a[31:2]) r = q[i].d;
    end
    return r;
  endfunction

  task automatic check_all();
    chk("buf_count", 32'(buf_count), 32'(q.size()));
    chk("WrStall", 32'(WrStall), 32'(q.size() == DEPTH));
    chk("bk_wr_valid", 32'(bk_wr_valid), 32'(q.size() != 0));
    chk("bk_rd_addr", bk_rd_addr, Mem_WrAddr);
    chk("ReadData", ReadData, model_rd(Mem_WrAddr, bk_rd_data));
    if (q.size() != 0) begin
      chk("bk_wr_addr", bk_wr_addr, q[0].a);
      chk("bk_wr_data", bk_wr_data, q[0].d);
    end
  endtask

  // One clock cycle: compare at the negedge, then advance the model on the edge.
  task automatic cycle();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    @(negedge clk);
    check_all();
    do_push = MemWrite && (q.size() < DEPTH);
    do_pop  = bk_wr_ready && (q.size() != 0);
    e.a     = {Mem_WrAddr[31:2], 2'b00};
    e.d     = Mem_WrData;
    @(posedge clk);
    if (do_pop) begin
      commits.push_back(q[0]);
      void'(q.pop_front());
    end
    if (do_push) q.push_back(e);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite   = 1'b1;
    Mem_WrAddr = a;
    Mem_WrData = d;
    cycle();
  endtask

  task automatic chk_commit(input int idx, input logic [31:0] a, input logic [31:0] d);
    if (commits.size() > idx) begin
      chk("commit_addr", commits[idx].a, a);
      chk("commit_data", commits[idx].d, d);
    end else begin
      chk("commit_missing", 32'(commits.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    n_total     = 0;
    n_pass      = 0;
    reset       = 1'b1;
    MemWrite    = 1'b0;
    Mem_WrAddr  = 32'h0;
    Mem_WrData  = 32'h0;
    bk_rd_data  = 32'h5555;
    bk_wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(buf_count), 32'd0);
    chk("rst_valid", 32'(bk_wr_valid), 32'd0);
    chk("rst_stall", 32'(WrStall), 32'd0);
    chk("rst_rd", ReadData, 32'h5555);
    reset = 1'b0;

    // Forwarding: youngest match wins, low address bits ignored.
    store(32'h100, 32'hAAAA0001);
    store(32'h104, 32'h00000022);
    store(32'h100, 32'hBBBB0002);
    MemWrite   = 1'b0;
    Mem_WrAddr = 32'h102;
    bk_rd_data = 32'hDEAD;
    #1;
    chk("fwd_young", ReadData, 32'hBBBB0002);
    chk("fwd_count", 32'(buf_count), 32'd3);
    Mem_WrAddr = 32'h200;
    #1;
    chk("fwd_miss", ReadData, 32'hDEAD);

    // Asynchronous reset mid-cycle with 3 entries queued.
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bk_wr_valid), 32'd0);
    chk("arst_count", 32'(buf_count), 32'd0);
    chk("arst_stall", 32'(WrStall), 32'd0);
    q.delete();
    commits.delete();
    @(posedge clk);
    #1;
    reset      = 1'b0;
    Mem_WrAddr = 32'h100;
    bk_rd_data = 32'h1234;
    #1;
    chk("arst_rd", ReadData, 32'h1234);
    cycle();

    // Fill and stall.
    for (int i = 0; i < 4; i++) store(32'h400 + 32'(4 * i), 32'h40 + 32'(i));
    chk("full_count", 32'(buf_count), 32'd4);
    chk("full_stall", 32'(WrStall), 32'd1);
    store(32'h300, 32'h3333);
    chk("blocked_count", 32'(buf_count), 32'd4);
    bk_wr_ready = 1'b1;
    cycle();
    chk("pulse_stall", 32'(WrStall), 32'd0);
    chk("pulse_count", 32'(buf_count), 32'd3);
    bk_wr_ready = 1'b0;
    cycle();
    chk("refill_count", 32'(buf_count), 32'd4);
    MemWrite    = 1'b0;
    bk_wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("fill_commits", 32'(commits.size()), 32'd5);
    chk_commit(0, 32'h400, 32'h40);
    chk_commit(1, 32'h404, 32'h41);
    chk_commit(2, 32'h408, 32'h42);
    chk_commit(3, 32'h40C, 32'h43);
    chk_commit(4, 32'h300, 32'h3333);

    // Ordering under random ready; the per-cycle check pins head stability.
    commits.delete();
    bk_wr_ready = 1'b0;
    store(32'h10, 32'h1);
    store(32'h14, 32'h2);
    store(32'h18, 32'h3);
    MemWrite = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bk_wr_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    bk_wr_ready = 1'b1;
    repeat (4) cycle();
    chk("ord_commits", 32'(commits.size()), 32'd3);
    chk_commit(0, 32'h10, 32'h1);
    chk_commit(1, 32'h14, 32'h2);
    chk_commit(2, 32'h18, 32'h3);

    // Simultaneous push/pop every cycle; pointers wrap twice.
    commits.delete();
    bk_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      store(32'h800 + 32'(4 * i), 32'h100 + 32'(i));
      chk("wrap_count", 32'(buf_count), 32'd1);
      chk("wrap_stall", 32'(WrStall), 32'd0);
      chk("wrap_latency", 32'(commits.size()), 32'(i));
    end
    MemWrite = 1'b0;
    cycle();
    chk("wrap_commits", 32'(commits.size()), 32'd10);
    for (int i = 0; i < 10; i++) chk_commit(i, 32'h800 + 32'(4 * i), 32'h100 + 32'(i));
    chk("wrap_empty", 32'(buf_count), 32'd0);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
